// File: rtl/fan_pkg.sv
// fan_pkg: shared state enum, duty constants and default timing parameters for the fan driver.
package fan_pkg;
    typedef enum logic [1:0] {ST_OFF, ST_KICK, ST_RUN, ST_RAMP_DOWN} fan_state_t;
    localparam int DUTY_W = 8;
    localparam logic [DUTY_W-1:0] DUTY_MAX = 8'd255;
    localparam int PRESCALE_DEF = 8;
    localparam int RAMP_TICKS_DEF = 50000;
    localparam int KICK_CYCLES_DEF = 25000000;
    localparam int TACH_WINDOW_DEF = 50000000;
    localparam int TACH_MIN_PULSES_DEF = 4;
endpackage

// File: rtl/fan_tach_monitor.sv
// fan_tach_monitor: tach synchronizer, falling-edge counter and sticky stall flag; built only with FAN_TACH_EN.
`ifdef FAN_TACH_EN
module fan_tach_monitor
    import fan_pkg::*;
#(
    parameter int TACH_WINDOW = TACH_WINDOW_DEF,
    parameter int TACH_MIN_PULSES = TACH_MIN_PULSES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic i_tach,
    input  logic i_run_valid,
    input  logic i_restart,
    input  logic i_clear,
    output logic o_stall
);
    localparam int WW = $clog2(TACH_WINDOW + 1);
    localparam int PW = $clog2(TACH_MIN_PULSES + 1);
    // [0],[1] are the synchronizer stages, [2] holds the previous synchronized sample
    logic [2:0] r_sync;
    logic [WW-1:0] r_win;
    logic [PW-1:0] r_pulses;
    logic r_stall;
    logic w_fall, w_end, w_clr_win;
    assign w_fall = r_sync[2] & ~r_sync[1];
    assign w_end = r_win == WW'(TACH_WINDOW - 1);
    assign w_clr_win = i_restart || w_end;
    assign o_stall = r_stall;
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync <= '0;
            r_win <= '0;
            r_pulses <= '0;
            r_stall <= 1'b0;
        end else begin
            r_sync <= {r_sync[1:0], i_tach};
            r_win <= w_clr_win ? '0 : r_win + 1'b1;
            r_pulses <= w_clr_win ? '0 :
                        (w_fall && r_pulses != PW'(TACH_MIN_PULSES)) ? r_pulses + 1'b1 : r_pulses;
            r_stall <= i_clear ? 1'b0 :
                       (w_end && i_run_valid && r_pulses < PW'(TACH_MIN_PULSES)) ? 1'b1 : r_stall;
        end
    end
endmodule
`endif

// File: rtl/fan_pwm_driver.sv
// fan_pwm_driver: fan_control demand to kick-started, slew-limited, glitch-free PWM; tach stall detect with FAN_TACH_EN.
module fan_pwm_driver
    import fan_pkg::*;
#(
    parameter int PRESCALE = PRESCALE_DEF,
    parameter int RAMP_TICKS = RAMP_TICKS_DEF,
    parameter int KICK_CYCLES = KICK_CYCLES_DEF,
    parameter int TACH_WINDOW = TACH_WINDOW_DEF,
    parameter int TACH_MIN_PULSES = TACH_MIN_PULSES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic fan_control,
    input  logic [DUTY_W-1:0] max_duty,
    input  logic fan_tach,
    output logic pwm_out,
    output logic fan_on,
    output logic [DUTY_W-1:0] duty,
    output logic stall
);
    localparam int PS_W = $clog2(PRESCALE + 1);
    localparam int RAMP_W = $clog2(RAMP_TICKS + 1);
    localparam int KICK_W = $clog2(KICK_CYCLES + 1);
    fan_state_t r_state, w_state_nx;
    logic [DUTY_W-1:0] r_duty, w_duty_nx, r_duty_q, r_pwm_cnt;
    logic [PS_W-1:0] r_ps;
    logic [RAMP_W-1:0] r_ramp;
    logic [KICK_W-1:0] r_kick;
    logic r_pwm, w_tick, w_kick_done, w_ps_tick, w_entry, w_stall;
    assign w_tick = r_ramp == RAMP_W'(RAMP_TICKS - 1);
    assign w_kick_done = r_kick == KICK_W'(KICK_CYCLES - 1);
    assign w_ps_tick = r_ps == PS_W'(PRESCALE - 1);
    assign w_entry = w_state_nx != r_state;
    assign pwm_out = r_pwm;
    assign fan_on = r_state != ST_OFF;
    assign duty = r_duty;
    assign stall = w_stall;
    // fan_control transitions are tested first so they win over a same-clock ramp step
    always_comb begin
        w_state_nx = r_state;
        w_duty_nx = r_duty;
        case (r_state)
            ST_OFF: begin
                w_state_nx = fan_control ? ST_KICK : ST_OFF;
                w_duty_nx = fan_control ? DUTY_MAX : '0;
            end
            ST_KICK: w_state_nx = !fan_control ? ST_RAMP_DOWN : w_kick_done ? ST_RUN : ST_KICK;
            ST_RUN: begin
                w_state_nx = fan_control ? ST_RUN : ST_RAMP_DOWN;
                if (fan_control && w_tick)
                    w_duty_nx = (r_duty < max_duty) ? r_duty + 1'b1 :
                                (r_duty > max_duty) ? r_duty - 1'b1 : r_duty;
            end
            default: begin
                w_duty_nx = (!fan_control && w_tick && r_duty != '0) ? r_duty - 1'b1 : r_duty;
                w_state_nx = fan_control ? ST_RUN : (w_duty_nx == '0) ? ST_OFF : ST_RAMP_DOWN;
            end
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_OFF;
            r_duty <= '0;
            r_ramp <= '0;
            r_kick <= '0;
            r_ps <= '0;
            r_pwm_cnt <= '0;
            r_duty_q <= '0;
            r_pwm <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_duty <= w_duty_nx;
            r_ramp <= (w_entry || w_tick) ? '0 : r_ramp + 1'b1;
            r_kick <= (r_state == ST_KICK) ? r_kick + 1'b1 : '0;
            r_ps <= w_ps_tick ? '0 : r_ps + 1'b1;
            r_pwm_cnt <= w_ps_tick ? r_pwm_cnt + 1'b1 : r_pwm_cnt;
            // duty_q only follows duty on the wrap clock so a period is never cut short
            r_duty_q <= (w_ps_tick && r_pwm_cnt == DUTY_MAX) ? r_duty : r_duty_q;
            r_pwm <= (r_duty_q == DUTY_MAX) || (r_pwm_cnt < r_duty_q);
        end
    end
`ifdef FAN_TACH_EN
    fan_tach_monitor #(
        .TACH_WINDOW(TACH_WINDOW),
        .TACH_MIN_PULSES(TACH_MIN_PULSES)
    ) u_tach (
        .clk(clk),
        .reset(reset),
        .i_tach(fan_tach),
        .i_run_valid(r_state == ST_RUN),
        .i_restart(w_entry),
        .i_clear(w_entry && w_state_nx == ST_OFF),
        .o_stall(w_stall)
    );
`else
    localparam int unused_tach_cfg = TACH_WINDOW + TACH_MIN_PULSES;
    logic w_unused_tach;
    assign w_unused_tach = fan_tach;
    assign w_stall = 1'b0;
`endif
endmodule

// File: tb/tb_fan_pwm_driver.sv
// tb_fan_pwm_driver: directed stimulus, per-cycle behavioural model compare plus literal checkpoints.
`timescale 1ns/1ps
module tb_fan_pwm_driver;
    localparam int PRESCALE = 1;
    localparam int RAMP = 4;
    localparam int KICK = 16;
    localparam int WIN = 64;
    localparam int MINP = 2;
    localparam int OFF = 0, KICKS = 1, RUN = 2, DOWN = 3;
`ifdef FAN_TACH_EN
    localparam int TACH = 1;
`else
    localparam int TACH = 0;
`endif
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic fan_control = 1'b0;
    logic fan_tach = 1'b1;
    logic [7:0] max_duty = 8'd128;
    logic pwm_out, fan_on, stall;
    logic [7:0] duty;
    int total = 0;
    int bad = 0;
    bit tach_en = 1'b0;
    bit m_valid = 1'b0;
    int m_st, m_age, m_duty, m_t, m_dq, m_win, m_pul;
    bit m_pwm, m_stall, m_tprev;

    fan_pwm_driver #(
        .PRESCALE(PRESCALE),
        .RAMP_TICKS(RAMP),
        .KICK_CYCLES(KICK),
        .TACH_WINDOW(WIN),
        .TACH_MIN_PULSES(MINP)
    ) dut (
        .clk(clk),
        .reset(reset),
        .fan_control(fan_control),
        .max_duty(max_duty),
        .fan_tach(fan_tach),
        .pwm_out(pwm_out),
        .fan_on(fan_on),
        .duty(duty),
        .stall(stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input int a, input int e);
        total++;
        if (a != e) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", n, a, e, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // tach: one falling edge every 20 clocks while enabled
    initial begin
        int ph = 0;
        forever begin
            @(negedge clk);
            if (tach_en) begin
                ph++;
                if (ph == 10) fan_tach = 1'b0;
                else if (ph == 20) begin
                    fan_tach = 1'b1;
                    ph = 0;
                end
            end
        end
    end

    // model in terms of time-in-state and absolute PWM phase
    always @(posedge clk) begin
        int nst, nd;
        bit tick, fall;
        m_valid = 1'b1;
        if (reset) begin
            m_st = OFF; m_age = 0; m_duty = 0; m_t = 0; m_dq = 0;
            m_pwm = 1'b0; m_stall = 1'b0; m_win = 0; m_pul = 0; m_tprev = fan_tach;
        end else begin
            m_pwm = (m_dq == 255) || (((m_t / PRESCALE) % 256) < m_dq);
            if (m_t % (256 * PRESCALE) == 256 * PRESCALE - 1) m_dq = m_duty;
            m_t++;
            tick = ((m_age + 1) % RAMP) == 0;
            nst = m_st;
            nd = m_duty;
            case (m_st)
                OFF: if (fan_control) begin nst = KICKS; nd = 255; end
                KICKS: if (!fan_control) nst = DOWN; else if (m_age + 1 == KICK) nst = RUN;
                RUN: if (!fan_control) nst = DOWN;
                     else if (tick) nd = m_duty + int'(max_duty > m_duty) - int'(max_duty < m_duty);
                default: if (fan_control) nst = RUN;
                         else begin
                             if (tick && m_duty > 0) nd = m_duty - 1;
                             if (nd == 0) nst = OFF;
                         end
            endcase
            fall = m_tprev && !fan_tach;
            m_tprev = fan_tach;
            if (TACH == 1) begin
                m_pul += int'(fall);
                if (m_win == WIN - 1) begin
                    if (m_st == RUN && m_pul < MINP) m_stall = 1'b1;
                    m_win = 0;
                    m_pul = 0;
                end else m_win++;
                if (nst != m_st) begin
                    m_win = 0;
                    m_pul = 0;
                    if (nst == OFF) m_stall = 1'b0;
                end
            end
            m_age = (nst != m_st) ? 0 : m_age + 1;
            m_st = nst;
            m_duty = nd;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("duty", int'(duty), m_duty);
            chk("fan_on", int'(fan_on), int'(m_st != OFF));
            chk("pwm_out", int'(pwm_out), int'(m_pwm));
            chk("stall", int'(stall), int'(m_stall));
        end
    end

    initial begin
        int hi;
        cyc(3);
        chk("rst_duty", int'(duty), 0);
        chk("rst_fan_on", int'(fan_on), 0);
        chk("rst_pwm", int'(pwm_out), 0);
        chk("rst_stall", int'(stall), 0);
        reset = 1'b0;
        cyc(2);
        fan_control = 1'b1;
        cyc(1);
        chk("kick_duty", int'(duty), 255);
        chk("kick_fan_on", int'(fan_on), 1);
        cyc(16);
        chk("run_entry_duty", int'(duty), 255);
        cyc(63);
        chk("stall_pre_window", int'(stall), 0);
        cyc(1);
        chk("stall_window_end", int'(stall), TACH);
        cyc(443);
        chk("run_duty_129", int'(duty), 129);
        cyc(1);
        chk("run_duty_128", int'(duty), 128);
        cyc(300);
        fan_control = 1'b0;
        cyc(512);
        chk("down_duty_1", int'(duty), 1);
        chk("down_fan_on", int'(fan_on), 1);
        cyc(1);
        chk("off_duty", int'(duty), 0);
        chk("off_fan_on", int'(fan_on), 0);
        chk("off_stall_clear", int'(stall), 0);
        cyc(260);
        chk("off_pwm", int'(pwm_out), 0);
        tach_en = 1'b1;
        cyc(10);
        fan_control = 1'b1;
        cyc(525);
        chk("rekick_duty_128", int'(duty), 128);
        fan_control = 1'b0;
        cyc(273);
        chk("down_duty_60", int'(duty), 60);
        fan_control = 1'b1;
        cyc(1);
        chk("resume_no_kick", int'(duty), 60);
        chk("resume_fan_on", int'(fan_on), 1);
        cyc(4);
        chk("resume_climb_61", int'(duty), 61);
        max_duty = 8'd64;
        cyc(600);
        chk("steady_duty_64", int'(duty), 64);
        hi = 0;
        repeat (256) begin
            @(negedge clk);
            hi += int'(pwm_out);
        end
        chk("pwm_high_64", hi, 64);
        chk("tach_ok_no_stall", int'(stall), 0);
        max_duty = 8'd255;
        cyc(1100);
        hi = 0;
        repeat (256) begin
            @(negedge clk);
            hi += int'(pwm_out);
        end
        chk("pwm_high_255", hi, 256);
        fan_control = 1'b0;
        cyc(1100);
        chk("full_ramp_off", int'(fan_on), 0);
        fan_control = 1'b1;
        cyc(5);
        reset = 1'b1;
        cyc(1);
        chk("kick_rst_duty", int'(duty), 0);
        chk("kick_rst_fan_on", int'(fan_on), 0);
        chk("kick_rst_pwm", int'(pwm_out), 0);
        chk("kick_rst_stall", int'(stall), 0);
        reset = 1'b0;
        fan_control = 1'b0;
        cyc(5);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
